// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected layer pipeline.
//   fc_link_state_t : control states of the inter-layer link stage.
//   fc_sat          : unsigned saturation of an activation to a narrower width,
//                     also used by the activation function unit (fc_func).
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } fc_link_state_t;

  // Clamp an unsigned value to the largest value representable in out_width bits.
  // The caller truncates the result to out_width bits.
  function automatic logic [31:0] fc_sat(input logic [31:0] in, input int unsigned out_width);
    logic [31:0] max_val;
    max_val = (out_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_width) - 32'd1);
    return (in > max_val) ? max_val : in;
  endfunction

endpackage

// File: rtl/fc_layer_link_if.sv
// fc_layer_link_if: activation stream and next-layer ibuf/control bundle.
//   i_valid, i_data   : activation beats from the upstream function unit
//   o_busy            : back-pressure towards the upstream function unit
//   o_ibuf_we/addr/wr_data : write port of the next layer's input buffer
//   i_next_busy       : busy flag of the next layer's controller
//   o_next_start      : one-cycle start pulse to the next layer
// Modports: master is taken by the link stage, slave by its environment.
interface fc_layer_link_if #(
  parameter int in_width   = 2,
  parameter int out_width  = 2,
  parameter int addr_width = 10
);

  logic                  i_valid;
  logic [in_width-1:0]   i_data;
  logic                  o_busy;
  logic                  o_ibuf_we;
  logic [addr_width-1:0] o_ibuf_addr;
  logic [out_width-1:0]  o_ibuf_wr_data;
  logic                  i_next_busy;
  logic                  o_next_start;

  modport master (
    input  i_valid, i_data, i_next_busy,
    output o_busy, o_ibuf_we, o_ibuf_addr, o_ibuf_wr_data, o_next_start
  );

  modport slave (
    output i_valid, i_data, i_next_busy,
    input  o_busy, o_ibuf_we, o_ibuf_addr, o_ibuf_wr_data, o_next_start
  );

endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: running maximum over the values written for one vector.
//   clk, rst  : clock and synchronous active-high reset
//   sample    : a value is being written this cycle
//   first     : the sampled value is the first of a new vector
//   idx, val  : index and saturated value being written
//   done      : the vector is complete; publish the result
//   max_idx, max_val : registered result, held until the next publish
//   valid     : one-cycle pulse when a result is published
module fc_argmax #(
  parameter int idx_width = 10,
  parameter int val_width = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic                 first,
  input  logic [idx_width-1:0] idx,
  input  logic [val_width-1:0] val,
  input  logic                 done,
  output logic [idx_width-1:0] max_idx,
  output logic [val_width-1:0] max_val,
  output logic                 valid
);

  logic [idx_width-1:0] run_idx;
  logic [val_width-1:0] run_val;

  // Strict greater-than keeps the lower index on ties; the first beat
  // of a vector always reloads so stale maxima never leak across vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_idx <= '0;
      run_val <= '0;
      max_idx <= '0;
      max_val <= '0;
      valid   <= 1'b0;
    end else begin
      if (sample && (first || (val > run_val))) begin
        run_idx <= idx;
        run_val <= val;
      end
      valid <= done;
      if (done) begin
        max_idx <= run_idx;
        max_val <= run_val;
      end
    end
  end

endmodule

// File: rtl/fc_layer_link.sv
// fc_layer_link: link stage between a fully-connected layer's activation
// output and the next layer's input buffer. Saturates each accepted beat,
// writes it sequentially into the ibuf, pulses start after a full vector and
// holds off the upstream unit while the next layer is still busy.
//   clk, rst       : clock and synchronous active-high reset
//   link (master)  : activation stream, ibuf write port, next-layer handshake
//   o_drop_err     : sticky, a beat arrived while it could not be accepted
//   o_argmax_idx/val/valid : per-vector argmax result
// Optional feature: define FC_LINK_ARGMAX_EN to build the argmax tracker;
// otherwise the argmax outputs are tied to zero.
module fc_layer_link
  import fc_pkg::*;
#(
  parameter int num_outputs = 1000,
  parameter int in_width    = 2,
  parameter int out_width   = 2,
  parameter int addr_width  = (num_outputs > 1) ? $clog2(num_outputs) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_layer_link_if.master       link,
  output logic                  o_drop_err,
  output logic [addr_width-1:0] o_argmax_idx,
  output logic [out_width-1:0]  o_argmax_val,
  output logic                  o_argmax_valid
);

  localparam logic [addr_width-1:0] last_addr = addr_width'(num_outputs - 1);

  fc_link_state_t        state, state_next;
  logic [addr_width-1:0] addr, addr_next;
  logic                  accept;
  logic                  drop;
  logic                  busy_next;
  logic                  wait_first;
  logic                  busy_q;
  logic                  start_q;
  logic                  we_q;
  logic [addr_width-1:0] addr_q;
  logic [out_width-1:0]  data_q;
  logic [in_width-1:0]   beat_data;
  logic [out_width-1:0]  sat_val;

  assign beat_data = link.i_data;
  assign sat_val   = out_width'(fc_sat(32'(beat_data), out_width));

  // State and write address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
    end
  end

  // Next-state logic. In IDLE, busy_q equals last cycle's i_next_busy, so it
  // doubles as the registered gate for the first beat of a vector. The state
  // sits in START while the final write is visible; the registered start
  // pulse and busy therefore appear one cycle later, during the first WAIT
  // cycle, which never exits so the next layer has time to raise its busy.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    accept     = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (link.i_valid && ((state == FILL) || !busy_q)) begin
          accept = 1'b1;
          if (addr == last_addr) begin
            state_next = START;
            addr_next  = '0;
          end else begin
            state_next = FILL;
            addr_next  = addr + addr_width'(1);
          end
        end
      end
      START: begin
        state_next = WAIT;
        addr_next  = '0;
      end
      WAIT: begin
        if (!wait_first && !link.i_next_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase
    busy_next = (state_next == WAIT) || ((state_next == IDLE) && link.i_next_busy);
    drop      = link.i_valid && !accept;
  end

  // Registered outputs: ibuf write port, start pulse, back-pressure, drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      wait_first <= 1'b0;
      o_drop_err <= 1'b0;
    end else begin
      we_q <= accept;
      if (accept) begin
        addr_q <= addr;
        data_q <= sat_val;
      end
      start_q    <= (state == START);
      busy_q     <= busy_next;
      wait_first <= (state == START);
      if (drop) begin
        o_drop_err <= 1'b1;
      end
    end
  end

  assign link.o_ibuf_we      = we_q;
  assign link.o_ibuf_addr    = addr_q;
  assign link.o_ibuf_wr_data = data_q;
  assign link.o_next_start   = start_q;
  assign link.o_busy         = busy_q;

`ifdef FC_LINK_ARGMAX_EN
  logic first_beat;
  logic vector_done;

  assign first_beat  = accept && (state == IDLE);
  assign vector_done = (state == START);

  fc_argmax #(
    .idx_width (addr_width),
    .val_width (out_width)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .sample  (accept),
    .first   (first_beat),
    .idx     (addr),
    .val     (sat_val),
    .done    (vector_done),
    .max_idx (o_argmax_idx),
    .max_val (o_argmax_val),
    .valid   (o_argmax_valid)
  );
`else
  assign o_argmax_idx   = '0;
  assign o_argmax_val   = '0;
  assign o_argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_link.sv
// tb_fc_layer_link: self-checking bench for fc_layer_link with a 4-entry
// vector, 4-bit activations saturated to 2 bits. A vector-level reference
// model predicts every output each cycle; directed scenarios pin the model
// with literal values, then randomized traffic exercises the rest.
module tb_fc_layer_link;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int OW = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drop_err;
  logic [AW-1:0] am_idx;
  logic [OW-1:0] am_val;
  logic          am_valid;

  fc_layer_link_if #(.in_width(IW), .out_width(OW), .addr_width(AW)) link ();

  fc_layer_link #(
    .num_outputs (N),
    .in_width    (IW),
    .out_width   (OW),
    .addr_width  (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .link           (link),
    .o_drop_err     (drop_err),
    .o_argmax_idx   (am_idx),
    .o_argmax_val   (am_val),
    .o_argmax_valid (am_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, vector-level view.
  int filled = 0;
  bit locked = 0;
  int age    = 0;
  bit prev_nb = 0;
  int run_max = 0, run_idx = 0, done_max = 0, done_idx = 0;
  int model_ibuf [N];
  bit e_we = 0, e_start = 0, e_busy = 0, e_drop = 0, e_av = 0;
  int e_addr = 0, e_data = 0, e_aidx = 0, e_aval = 0;

  // Observed DUT behaviour.
  int dut_ibuf [N];
  int write_count = 0, start_count = 0, av_count = 0;
  int cap_idx = 0, cap_val = 0;

  // Stimulus-side next-layer emulation.
  int nb_hold = 0;
  int nb_len = 3;
  bit nb_force = 0;

  // Model: a vector is N accepted beats; the write appears one cycle after a
  // beat, start two cycles after the last beat, and the link stays locked
  // (every beat dropped) until the next layer releases it.
  always @(posedge clk) begin
    bit v;
    bit nb;
    bit acc;
    int d;
    if (rst) begin
      filled = 0; locked = 0; age = 0; prev_nb = 0;
      run_max = 0; run_idx = 0; done_max = 0; done_idx = 0;
      e_we = 0; e_start = 0; e_busy = 0; e_drop = 0; e_av = 0;
      e_addr = 0; e_data = 0; e_aidx = 0; e_aval = 0;
    end else begin
      v  = link.i_valid;
      nb = link.i_next_busy;
      d  = (int'(link.i_data) > 3) ? 3 : int'(link.i_data);
      e_we = 0; e_start = 0; e_av = 0;
      if (locked) begin
        if (v) e_drop = 1;
        if (age >= 2 && !nb) locked = 0;
        else age++;
        e_start = locked && (age == 1);
        e_busy  = locked && (age >= 1);
`ifdef FC_LINK_ARGMAX_EN
        if (e_start) begin
          e_av = 1; e_aidx = done_idx; e_aval = done_max;
        end
`endif
      end else begin
        acc = v && (filled > 0 || !prev_nb);
        if (v && !acc) e_drop = 1;
        if (acc) begin
          e_we = 1; e_addr = filled; e_data = d;
          model_ibuf[filled] = d;
          if (filled == 0 || d > run_max) begin
            run_max = d; run_idx = filled;
          end
          filled++;
          if (filled == N) begin
            locked = 1; age = 0; filled = 0;
            done_max = run_max; done_idx = run_idx;
          end
        end
        e_busy = !locked && (filled == 0) && nb;
      end
      prev_nb = nb;
    end
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic checkOutput();
    checkValue("ibuf_we", int'(link.o_ibuf_we), int'(e_we));
    if (e_we) begin
      checkValue("ibuf_addr", int'(link.o_ibuf_addr), e_addr);
      checkValue("ibuf_wr_data", int'(link.o_ibuf_wr_data), e_data);
    end
    checkValue("next_start", int'(link.o_next_start), int'(e_start));
    checkValue("busy", int'(link.o_busy), int'(e_busy));
    checkValue("drop_err", int'(drop_err), int'(e_drop));
`ifdef FC_LINK_ARGMAX_EN
    checkValue("argmax_valid", int'(am_valid), int'(e_av));
    checkValue("argmax_idx", int'(am_idx), e_aidx);
    checkValue("argmax_val", int'(am_val), e_aval);
`else
    checkValue("argmax_valid", int'(am_valid), 0);
    checkValue("argmax_idx", int'(am_idx), 0);
    checkValue("argmax_val", int'(am_val), 0);
`endif
    if (link.o_ibuf_we) begin
      dut_ibuf[link.o_ibuf_addr] = int'(link.o_ibuf_wr_data);
      write_count++;
    end
    if (link.o_next_start) start_count++;
    if (am_valid) begin
      av_count++; cap_idx = int'(am_idx); cap_val = int'(am_val);
    end
  endtask

  always @(negedge clk) checkOutput();

  // One cycle of stimulus; the emulated next layer raises busy for nb_len
  // cycles once the model says a start pulse is showing.
  task automatic applyStimulus(input bit v, input int d);
    link.i_valid = v;
    link.i_data  = IW'(d);
    if (nb_hold > 0) begin
      link.i_next_busy = 1'b1;
      nb_hold--;
    end else begin
      link.i_next_busy = nb_force;
    end
    @(posedge clk);
    #1;
    if (e_start) nb_hold = nb_len;
  endtask

  task automatic sendVector(input int d0, input int d1, input int d2, input int d3);
    applyStimulus(1, d0); applyStimulus(1, d1); applyStimulus(1, d2); applyStimulus(1, d3);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1; nb_force = 0; nb_hold = 0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic checkIbuf(input string tag, input int v0, input int v1, input int v2, input int v3);
    int exp_v [N];
    exp_v[0] = v0; exp_v[1] = v1; exp_v[2] = v2; exp_v[3] = v3;
    for (int i = 0; i < N; i++) begin
      checkValue($sformatf("%s dut_ibuf[%0d]", tag, i), dut_ibuf[i], exp_v[i]);
      checkValue($sformatf("%s model_ibuf[%0d]", tag, i), model_ibuf[i], exp_v[i]);
    end
  endtask

  initial begin
    int sc;
    int wc;
    link.i_valid = 1'b0; link.i_data = '0; link.i_next_busy = 1'b0;
    rst = 1'b1;
    idle(3);
    $display("[TB] reset state");
    checkValue("reset we", int'(link.o_ibuf_we), 0);
    checkValue("reset start", int'(link.o_next_start), 0);
    checkValue("reset busy", int'(link.o_busy), 0);
    checkValue("reset drop_err", int'(drop_err), 0);
    checkValue("reset argmax_valid", int'(am_valid), 0);
    rst = 1'b0;

    $display("[TB] full vector");
    sendVector(1, 2, 3, 0);
    idle(12);
    checkIbuf("full", 1, 2, 3, 0);
    checkValue("full start_count", start_count, 1);

    $display("[TB] saturation");
    sendVector(9, 2, 3, 15);
    idle(12);
    checkIbuf("sat", 3, 2, 3, 3);
    checkValue("sat start_count", start_count, 2);

    $display("[TB] drop during start pulse");
    sc = start_count; wc = write_count;
    sendVector(2, 2, 2, 2);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    idle(12);
    checkValue("pulse drop_err", int'(drop_err), 1);
    checkValue("pulse writes", write_count - wc, 4);
    checkValue("pulse starts", start_count - sc, 1);
    sendVector(3, 0, 0, 1);
    idle(12);
    checkIbuf("after_drop", 3, 0, 0, 1);

    $display("[TB] back-pressure in idle");
    doReset();
    wc = write_count; sc = start_count;
    nb_force = 1;
    idle(2);
    applyStimulus(1, 1); applyStimulus(1, 1); applyStimulus(1, 1);
    checkValue("bp drop_err", int'(drop_err), 1);
    checkValue("bp writes", write_count - wc, 0);
    nb_force = 0;
    applyStimulus(0, 0);
    sendVector(2, 1, 1, 1);
    idle(12);
    checkIbuf("bp", 2, 1, 1, 1);
    checkValue("bp starts", start_count - sc, 1);

    $display("[TB] reset mid-fill");
    doReset();
    applyStimulus(1, 1); applyStimulus(1, 2);
    rst = 1'b1;
    applyStimulus(0, 0);
    rst = 1'b0;
    checkValue("midrst we", int'(link.o_ibuf_we), 0);
    checkValue("midrst busy", int'(link.o_busy), 0);
    checkValue("midrst drop_err", int'(drop_err), 0);
    sc = start_count;
    idle(6);
    checkValue("midrst no start", start_count - sc, 0);
    sendVector(3, 2, 1, 0);
    idle(12);
    checkIbuf("midrst", 3, 2, 1, 0);
    checkValue("midrst starts", start_count - sc, 1);

    $display("[TB] argmax vector");
    sendVector(1, 3, 3, 2);
    idle(12);
    checkIbuf("argmax", 1, 3, 3, 2);
`ifdef FC_LINK_ARGMAX_EN
    checkValue("argmax idx", cap_idx, 1);
    checkValue("argmax val", cap_val, 3);
    checkValue("argmax pulses", av_count, start_count);
`else
    checkValue("argmax pulses", av_count, 0);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      nb_len   = $urandom_range(1, 5);
      nb_force = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 15));
    end
    rst = 1'b0; nb_force = 0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_link.md
# fc_layer_link

Inter-layer link stage between one fully-connected layer's activation function output and the next layer's input buffer. It accepts one activation per valid beat and saturates it to the next layer's datatype width. It writes the values sequentially into the next layer's ibuf, then issues a single start pulse once a full vector has landed. It also holds off the upstream function unit while the next layer is still consuming its buffer.

## Interface
Parameters:
- `num_outputs`, 1000: activations per vector; this is the upstream layer's output_size.
- `in_width`, 2: upstream activation width (output_datatype_size).
- `out_width`, 2: next-layer datatype_size; must satisfy out_width <= in_width.
- `addr_width`, $clog2(num_outputs): width of the ibuf write address.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_valid`  in  1: upstream activation beat is valid.
- `i_data`  in  in_width: unsigned activation from the upstream function unit.
- `o_busy`  out  1: back-pressure to upstream; drives the upstream i_next_busy.
- `o_ibuf_we`  out  1: next-layer ibuf write enable.
- `o_ibuf_addr`  out  addr_width: next-layer ibuf write address.
- `o_ibuf_wr_data`  out  out_width: saturated activation.
- `i_next_busy`  in  1: next layer's ctrl busy.
- `o_next_start`  out  1: one-cycle start pulse to the next layer.
- `o_drop_err`  out  1: sticky flag; a beat arrived while o_busy=1.
- `o_argmax_idx`  out  addr_width: argmax index (see Configuration).
- `o_argmax_val`  out  out_width: argmax value.
- `o_argmax_valid`  out  1: argmax result pulse.

## Operation
States are IDLE, FILL, START and WAIT.
- **IDLE:**
  - A beat is accepted when i_valid=1 and o_busy=0.
  - The first accepted beat writes address 0 and moves the state to FILL.
- **FILL:**
  - Each accepted beat writes the current address, then the address increments.
  - The beat written to address num_outputs-1 moves the state to START.
  - If that beat is also the first beat (num_outputs=1), the state goes IDLE->START directly.
- **START:**
  - o_next_start=1 for exactly one cycle, then the state moves to WAIT.
  - The write address returns to 0.
- **WAIT:**
  - The first WAIT cycle is unconditional.
  - After that, the state returns to IDLE on the first cycle with i_next_busy=0.
  - The next layer must raise busy within one cycle of start.
- **o_busy:** 1 in START and WAIT, and in IDLE while i_next_busy=1. It is 0 in FILL.
- **Saturation:** if i_data > 2^out_width-1, the written value is 2^out_width-1; otherwise it is i_data[out_width-1:0].
- **Dropped beats:** a beat with i_valid=1 while o_busy=1 is discarded, sets o_drop_err, and leaves the address unchanged.
  - o_drop_err clears only on rst.

## Timing
- Reset value of every output is 0; the state resets to IDLE and the address to 0.
- **Write latency:** o_ibuf_we/addr/wr_data are registered and appear the cycle after the accepted beat.
  - Back-to-back beats produce back-to-back writes.
- **Start latency:** o_next_start asserts the cycle after the final write appears, i.e. two cycles after the final beat is accepted.
- **o_busy timing:** o_busy is registered and rises in the same cycle as o_next_start.
- **IDLE gating:** IDLE acceptance is gated by the registered copy of i_next_busy.
  - A beat presented in the cycle after i_next_busy falls is accepted.
- **Reset mid-operation:** a partial vector is abandoned and no start is issued.
  - Previously written ibuf contents are left as is.
- **Simultaneous events:** i_valid in the START cycle is a drop, and sets o_drop_err.

## Configuration
- **`FC_LINK_ARGMAX_EN` defined:** a running maximum is tracked over the written values of each vector.
  - Comparison uses the saturated values; on ties the lower index is kept.
  - o_argmax_idx and o_argmax_val are registered and hold until the next vector completes.
  - o_argmax_valid pulses together with o_next_start.
  - The tracker resets at the first beat of each vector.
- **Not defined:** no tracker logic is built; o_argmax_idx, o_argmax_val and o_argmax_valid are tied to 0.

## Structure
- **Shared package `fc_pkg`:**
  - the state enum `fc_link_state_t` (IDLE, FILL, START, WAIT);
  - the saturation function `fc_sat(in, out_width)`, also reused by fc_func.
- **Sub-module `fc_argmax`:** holds the running-max compare/register.
  - It is instantiated only under FC_LINK_ARGMAX_EN.

## Test plan
- **Full vector:** num_outputs=4, in=out=2, beats 1,2,3,0 back-to-back.
  - Writes addr 0..3 with 1,2,3,0.
  - o_next_start is a single pulse two cycles after the last beat.
  - o_busy=1 from the start pulse until i_next_busy falls.
- **Saturation:** in_width=4, out_width=2, beats 0x9,0x2,0x3,0xF.
  - Written values are 3,2,3,3.
- **Back-pressure:** i_next_busy=1 in IDLE, then i_valid held.
  - No write occurs and o_drop_err=1.
  - After i_next_busy falls, the next beat writes addr 0.
- **Drop in START/WAIT:** i_valid=1 during the start pulse.
  - o_drop_err=1, no write, and the next vector still starts at addr 0.
- **Reset mid-fill:** rst after 2 of 4 beats.
  - All outputs are 0 and no start is issued.
  - A fresh 4-beat vector writes 0..3 and starts.
- **Argmax (FC_LINK_ARGMAX_EN):** values 1,3,3,2.
  - o_argmax_idx=1 and o_argmax_val=3, with o_argmax_valid coincident with o_next_start.
